// File: rtl/ctrl_types_pkg.sv
// Shared controller types: the operation command encoding and host front-end states.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    NOOP   = 2'b00,
    READ   = 2'b01,
    UPSERT = 2'b10,
    DELETE = 2'b11
  } operation_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } host_if_state_e;

endpackage

// File: rtl/cache_host_if.sv
// Host request front end: accepts one request, issues a one-cycle command to the
// controller, waits for the rdy rising edge (or watchdog expiry) and holds the response.
module cache_host_if
  import ctrl_types_pkg::*;
#(
  parameter int KEY_WIDTH      = 16,
  parameter int VALUE_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  operation_e             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_succ,
  output logic                   rsp_timeout,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output operation_e             operation_out,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  input  logic                   rdy_in,
  input  logic                   op_succ_in,
  input  logic [VALUE_WIDTH-1:0] value_in
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  host_if_state_e  state_q;
  host_if_state_e  state_d;
  operation_e      op_q;
  logic            rdy_q;
  logic [WD_W-1:0] wd_q;
  logic            rdy_rise;
  logic            wd_expired;

  assign rdy_rise   = rdy_in & ~rdy_q;
  assign wd_expired = (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // operation_out is decoded from state so an async reset forces NOOP at once.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    operation_out = NOOP;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (req_op == NOOP) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        operation_out = op_q;
        state_d       = WAIT;
      end
      WAIT: begin
        if (rdy_rise || wd_expired) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A rdy edge in the same cycle as watchdog expiry is a normal completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= NOOP;
      key_out     <= '0;
      value_out   <= '0;
      rsp_succ    <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_value   <= '0;
      rdy_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      rdy_q <= rdy_in;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            key_out     <= req_key;
            value_out   <= req_value;
            rsp_succ    <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_value   <= '0;
          end
        end
        ISSUE: begin
          wd_q <= '0;
        end
        WAIT: begin
          if (!wd_expired) begin
            wd_q <= wd_q + 1'b1;
          end
          if (rdy_rise) begin
            rsp_succ    <= op_succ_in;
            rsp_timeout <= 1'b0;
            rsp_value   <= (op_q == READ) ? value_in : '0;
          end else if (wd_expired) begin
            rsp_succ    <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_value   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_host_if.sv
// Directed bench for cache_host_if: completion, failure, timeout, held rdy, NOOP and reset.
module tb_cache_host_if;
  import ctrl_types_pkg::*;

  localparam int KW = 16;
  localparam int VW = 64;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  operation_e    req_op;
  logic [KW-1:0] req_key;
  logic [VW-1:0] req_value;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_succ;
  logic          rsp_timeout;
  logic [VW-1:0] rsp_value;
  operation_e    operation_out;
  logic [KW-1:0] key_out;
  logic [VW-1:0] value_out;
  logic          rdy_in;
  logic          op_succ_in;
  logic [VW-1:0] value_in;

  int checks   = 0;
  int failures = 0;
  int n;

  cache_host_if #(
    .KEY_WIDTH(KW),
    .VALUE_WIDTH(VW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_key(req_key),
    .req_value(req_value),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_succ(rsp_succ),
    .rsp_timeout(rsp_timeout),
    .rsp_value(rsp_value),
    .operation_out(operation_out),
    .key_out(key_out),
    .value_out(value_out),
    .rdy_in(rdy_in),
    .op_succ_in(op_succ_in),
    .value_in(value_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input operation_e op, input logic [KW-1:0] key,
                                input logic [VW-1:0] value);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_value = value;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = NOOP;
    req_key    = '0;
    req_value  = '0;
    rsp_ready  = 1'b0;
    rdy_in     = 1'b0;
    op_succ_in = 1'b0;
    value_in   = '0;
    #3;
    check_output("rst_req_ready", 64'(req_ready), 64'h1);
    check_output("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check_output("rst_op_out", 64'(operation_out), 64'(NOOP));
    check_output("rst_key_out", 64'(key_out), 64'h0);
    check_output("rst_value_out", value_out, 64'h0);
    check_output("rst_rsp_fields", {rsp_value[61:0], rsp_succ, rsp_timeout}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // READ with rdy rising 3 cycles after the issue cycle
    $display("[TB] READ completion");
    apply_stimulus(READ, 16'h0012, 64'hAAAA);
    tick();
    req_valid = 1'b0;
    check_output("read_issue_op", 64'(operation_out), 64'(READ));
    check_output("read_issue_ready", 64'(req_ready), 64'h0);
    check_output("read_key_out", 64'(key_out), 64'h0012);
    tick();
    check_output("read_wait_op", 64'(operation_out), 64'(NOOP));
    tick();
    tick();
    rdy_in     = 1'b1;
    op_succ_in = 1'b1;
    value_in   = 64'hDEADBEEF;
    check_output("read_not_done", 64'(rsp_valid), 64'h0);
    tick();
    check_output("read_rsp_valid", 64'(rsp_valid), 64'h1);
    check_output("read_rsp_succ", 64'(rsp_succ), 64'h1);
    check_output("read_rsp_value", rsp_value, 64'hDEADBEEF);
    check_output("read_rsp_timeout", 64'(rsp_timeout), 64'h0);
    rsp_ready = 1'b1;
    rdy_in    = 1'b0;
    tick();
    rsp_ready = 1'b0;
    check_output("read_back_idle", 64'(req_ready), 64'h1);
    check_output("read_rsp_dropped", 64'(rsp_valid), 64'h0);

    // UPSERT failing at the rdy edge; read data must not leak into the response
    $display("[TB] UPSERT failure");
    apply_stimulus(UPSERT, 16'h0005, 64'h1234);
    tick();
    req_valid = 1'b0;
    check_output("ups_issue_op", 64'(operation_out), 64'(UPSERT));
    tick();
    tick();
    rdy_in     = 1'b1;
    op_succ_in = 1'b0;
    value_in   = 64'hFFFF;
    tick();
    check_output("ups_rsp_valid", 64'(rsp_valid), 64'h1);
    check_output("ups_rsp_succ", 64'(rsp_succ), 64'h0);
    check_output("ups_rsp_value", rsp_value, 64'h0);
    check_output("ups_rsp_timeout", 64'(rsp_timeout), 64'h0);
    tick();
    check_output("ups_hold_valid", 64'(rsp_valid), 64'h1);
    check_output("ups_key_stable", 64'(key_out), 64'h0005);
    check_output("ups_value_stable", value_out, 64'h1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // rdy_in held high: no edge, so only the watchdog completes it
    $display("[TB] rdy held high");
    op_succ_in = 1'b1;
    apply_stimulus(READ, 16'h0077, 64'h9);
    tick();
    req_valid = 1'b0;
    for (int i = 2; i <= TO + 1; i++) begin
      tick();
      check_output($sformatf("held_no_rsp_c%0d", i), 64'(rsp_valid), 64'h0);
    end
    tick();
    check_output("held_rsp_valid", 64'(rsp_valid), 64'h1);
    check_output("held_rsp_timeout", 64'(rsp_timeout), 64'h1);
    check_output("held_rsp_succ", 64'(rsp_succ), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("held_stable_valid", 64'(rsp_valid), 64'h1);
      check_output("held_stable_fields",
                   {rsp_value[61:0], rsp_succ, rsp_timeout}, 64'h1);
      check_output("held_req_ready", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    rdy_in    = 1'b0;
    tick();
    rsp_ready = 1'b0;

    // DELETE with no rdy edge at all: response 10 cycles after accept
    $display("[TB] DELETE timeout");
    apply_stimulus(DELETE, 16'h0033, 64'h0);
    tick();
    req_valid = 1'b0;
    check_output("del_issue_op", 64'(operation_out), 64'(DELETE));
    n = 1;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check_output("del_latency", 64'(n), 64'(TO + 2));
    check_output("del_rsp_succ", 64'(rsp_succ), 64'h0);
    check_output("del_rsp_timeout", 64'(rsp_timeout), 64'h1);
    check_output("del_rsp_value", rsp_value, 64'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // rdy edge in the last WAIT cycle wins over watchdog expiry
    $display("[TB] edge vs expiry");
    apply_stimulus(READ, 16'h0044, 64'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 2; i <= TO + 1; i++) tick();
    rdy_in     = 1'b1;
    op_succ_in = 1'b1;
    value_in   = 64'h55;
    tick();
    check_output("tie_rsp_valid", 64'(rsp_valid), 64'h1);
    check_output("tie_rsp_timeout", 64'(rsp_timeout), 64'h0);
    check_output("tie_rsp_value", rsp_value, 64'h55);
    rsp_ready = 1'b1;
    rdy_in    = 1'b0;
    tick();
    rsp_ready = 1'b0;

    // NOOP goes straight to a failed response with no command
    $display("[TB] NOOP");
    apply_stimulus(NOOP, 16'h0001, 64'h1);
    tick();
    req_valid = 1'b0;
    check_output("noop_op_out", 64'(operation_out), 64'(NOOP));
    check_output("noop_rsp_valid", 64'(rsp_valid), 64'h1);
    check_output("noop_rsp_succ", 64'(rsp_succ), 64'h0);
    check_output("noop_rsp_timeout", 64'(rsp_timeout), 64'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during WAIT drops the command immediately
    $display("[TB] reset in WAIT");
    apply_stimulus(UPSERT, 16'h00AB, 64'h77);
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_op_out", 64'(operation_out), 64'(NOOP));
    check_output("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check_output("mid_rst_key_out", 64'(key_out), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("post_rst_ready", 64'(req_ready), 64'h1);
    check_output("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    apply_stimulus(READ, 16'h0099, 64'h0);
    tick();
    req_valid = 1'b0;
    check_output("post_rst_issue", 64'(operation_out), 64'(READ));
    tick();
    rdy_in     = 1'b1;
    op_succ_in = 1'b1;
    value_in   = 64'hCAFE;
    tick();
    check_output("post_rst_rsp_valid2", 64'(rsp_valid), 64'h1);
    check_output("post_rst_rsp_value", rsp_value, 64'hCAFE);
    check_output("post_rst_rsp_succ", 64'(rsp_succ), 64'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
